channel_demux_bank: RTL and testbench

- Parametrised successor of the fixed 64-channel sample demux. It captures one input sample per divider tick and writes it into one of NUM_CH channel registers.
- The target channel is either supplied on an index port (addressed mode) or generated by an internal write pointer (sequential mode).
- Adds a valid/ready handshake, per-channel sticky update flags, a frame-complete pulse and out-of-range detection.
- Sits between the sample source (ADC/serial deframer) and the per-channel signal consumers.

---
 rtl/channel_demux_pkg.sv | 23 ++
 rtl/channel_demux_bank_if.sv | 29 ++
 rtl/tick_divider.sv | 33 +++
 rtl/channel_demux_bank.sv | 112 +++++++++++
 tb/tb_channel_demux_bank.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_demux_pkg.sv
// Shared constants, mode encoding and width helpers for the channel demux bank.
package channel_demux_pkg;

  localparam int unsigned DEF_DATA_W   = 11;
  localparam int unsigned DEF_NUM_CH   = 64;
  localparam int unsigned DEF_TICK_DIV = 11;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_SEQ  = 1'b1
  } mode_e;

  // Width of the divider count; a divide-by-one still needs a one-bit register.
  function automatic int unsigned cnt_width(int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Width of a channel index for a bank of n channels.
  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_demux_bank_if.sv
// Sample input handshake between the sample source and the demux bank.
interface channel_demux_bank_if
  import channel_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NUM_CH = DEF_NUM_CH
);
  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_chan;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_chan,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_chan,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running divider: tick_o is high for one cycle out of every TICK_DIV.
module tick_divider
  import channel_demux_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int unsigned    CntW   = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap unconditionally so the cadence never depends on traffic.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With TICK_DIV == 1 the count is stuck at 0 and the tick is always high.
  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/channel_demux_bank.sv
// Captures one sample per divider tick into one of NUM_CH channel registers,
// addressed either by in_chan or by an internal sequential write pointer.
module channel_demux_bank
  import channel_demux_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  channel_demux_bank_if.slave      in_if,
  input  logic                     seq_mode_i,
  input  logic                     seq_restart_i,
  input  logic                     clr_updated_i,
  output logic [NUM_CH*DATA_W-1:0] ch_data_o,
  output logic [NUM_CH-1:0]        ch_updated_o,
  output logic                     frame_done_o,
  output logic                     err_oor_o
);
  localparam int unsigned     CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W-1:0] LastCh   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NumChExt = (CH_W + 1)'(NUM_CH);

  logic            tick;
  mode_e           mode;
  logic            accept;
  logic            oor;
  logic            wr_en;
  logic            at_last;
  logic [CH_W-1:0] wr_sel;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            frame_done_q, frame_done_d;
  logic            err_oor_q, err_oor_d;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  assign in_if.in_ready = tick;

  // Decode the accept, its target channel and the pointer/pulse next state.
  always_comb begin
    mode    = mode_e'(seq_mode_i);
    accept  = in_if.in_valid & tick;
    at_last = (ptr_q == LastCh);
    wr_sel  = (mode == MODE_SEQ) ? ptr_q : in_if.in_chan;
    // Only reachable when NUM_CH is not a power of two.
    oor     = (mode == MODE_ADDR) && ({1'b0, in_if.in_chan} >= NumChExt);
    wr_en   = accept & ~oor;

    frame_done_d = accept & (mode == MODE_SEQ) & at_last;
    err_oor_d    = accept & oor;

    ptr_d = ptr_q;
    if (accept && (mode == MODE_SEQ)) begin
      ptr_d = at_last ? '0 : ptr_q + 1'b1;
    end
    // Restart wins over the increment; the write itself still used the old pointer.
    if (seq_restart_i) begin
      ptr_d = '0;
    end
  end

  // Write pointer and the one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      frame_done_q <= 1'b0;
      err_oor_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      frame_done_q <= frame_done_d;
      err_oor_q    <= err_oor_d;
    end
  end

  assign frame_done_o = frame_done_q;
  assign err_oor_o    = err_oor_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic              hit;
    logic [DATA_W-1:0] data_q, data_d;
    logic              upd_q, upd_d;

    // A write to this channel sets its flag even when the clear is coincident.
    always_comb begin
      hit    = wr_en && (wr_sel == CH_W'(k));
      data_d = hit ? in_if.in_data : data_q;
      upd_d  = hit ? 1'b1 : (clr_updated_i ? 1'b0 : upd_q);
    end

    // Channel sample register and its sticky update flag.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        data_q <= '0;
        upd_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        upd_q  <= upd_d;
      end
    end

    assign ch_data_o[k*DATA_W +: DATA_W] = data_q;
    assign ch_updated_o[k]               = upd_q;
  end

endmodule

// File: tb/tb_channel_demux_bank.sv
// Scoreboard bench: the driver pushes the expected bank state per event, a
// monitor pops and compares after each event and checks idle cycles and cadence.
module tb_channel_demux_bank;
  import channel_demux_pkg::*;

  localparam int DATA_W   = 11;
  localparam int NUM_CH   = 40;
  localparam int TICK_DIV = 3;
  localparam int BUS_W    = NUM_CH * DATA_W;
  localparam int CH_W     = ch_width(NUM_CH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              seq_mode;
  logic              seq_restart;
  logic              clr_updated;
  logic [BUS_W-1:0]  ch_data;
  logic [NUM_CH-1:0] ch_updated;
  logic              frame_done;
  logic              err_oor;

  channel_demux_bank_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus_if ();

  channel_demux_bank #(
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_if         (bus_if),
    .seq_mode_i    (seq_mode),
    .seq_restart_i (seq_restart),
    .clr_updated_i (clr_updated),
    .ch_data_o     (ch_data),
    .ch_updated_o  (ch_updated),
    .frame_done_o  (frame_done),
    .err_oor_o     (err_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0]  data;
    logic [NUM_CH-1:0] flags;
    logic              fd;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain arrays and an integer pointer.
  logic [DATA_W-1:0] m_data [NUM_CH];
  bit                m_flag [NUM_CH];
  int                m_ptr;

  function automatic exp_t snap(logic fd, logic er);
    exp_t e;
    for (int k = 0; k < NUM_CH; k++) begin
      e.data[k*DATA_W +: DATA_W] = m_data[k];
      e.flags[k]                 = m_flag[k];
    end
    e.fd  = fd;
    e.err = er;
    return e;
  endfunction

  task automatic chk(string name, logic [BUS_W-1:0] got, logic [BUS_W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_data[k] = '0;
      m_flag[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic model_accept(bit seq, int chan, int data, bit rst_ptr, bit clr);
    int tgt;
    bit fd = 1'b0;
    bit er = 1'b0;
    if (seq) begin
      tgt   = m_ptr;
      fd    = (m_ptr == NUM_CH - 1);
      m_ptr = (m_ptr + 1) % NUM_CH;
    end else begin
      tgt = chan;
    end
    if (rst_ptr) m_ptr = 0;
    if (clr) foreach (m_flag[k]) m_flag[k] = 1'b0;
    if (tgt < NUM_CH) begin
      m_data[tgt] = DATA_W'(data);
      m_flag[tgt] = 1'b1;
    end else begin
      er = 1'b1;
    end
    exp_q.push_back(snap(fd, er));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus_if.in_valid = 1'b0;
    model_reset();
    exp_q.push_back(snap(1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Standalone control pulse with no sample offered; at least one of the two must be set.
  task automatic pulse(bit rst_ptr, bit clr);
    @(negedge clk);
    seq_restart = rst_ptr;
    clr_updated = clr;
    if (rst_ptr) m_ptr = 0;
    if (clr) foreach (m_flag[k]) m_flag[k] = 1'b0;
    exp_q.push_back(snap(1'b0, 1'b0));
    @(negedge clk);
    seq_restart = 1'b0;
    clr_updated = 1'b0;
  endtask

  // Offer one sample and hold it until the bank is ready; control pulses ride on the accept.
  task automatic send(bit seq, int chan, int data, bit rst_ptr, bit clr);
    bit done = 1'b0;
    @(negedge clk);
    seq_mode        = seq;
    bus_if.in_chan  = CH_W'(chan);
    bus_if.in_data  = DATA_W'(data);
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < TICK_DIV + 2 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (bus_if.in_ready) begin
        seq_restart = rst_ptr;
        clr_updated = clr;
        model_accept(seq, chan, data, rst_ptr, clr);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake: in_ready not seen within %0d cycles, required 1", TICK_DIV + 2);
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    seq_restart     = 1'b0;
    clr_updated     = 1'b0;
  endtask

  initial begin : monitor
    bit   pend_evt = 1'b0;
    bit   pend_rst = 1'b0;
    bit   armed    = 1'b0;
    int   cnt      = 0;
    exp_t last;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      // Outputs now reflect the previous rising edge.
      if (pend_rst) cnt = 0;
      else cnt = (cnt + 1) % TICK_DIV;
      if (pend_evt) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: DUT event at %0t with no expected entry", $time);
        end else begin
          e     = exp_q.pop_front();
          last  = e;
          armed = 1'b1;
          chk("ch_data", ch_data, e.data);
          chk("ch_updated", BUS_W'(ch_updated), BUS_W'(e.flags));
          chk("frame_done", BUS_W'(frame_done), BUS_W'(e.fd));
          chk("err_oor", BUS_W'(err_oor), BUS_W'(e.err));
        end
      end else if (armed) begin
        chk("idle_ch_data", ch_data, last.data);
        chk("idle_ch_updated", BUS_W'(ch_updated), BUS_W'(last.flags));
        chk("idle_frame_done", BUS_W'(frame_done), '0);
        chk("idle_err_oor", BUS_W'(err_oor), '0);
      end
      if (armed) chk("in_ready", BUS_W'(bus_if.in_ready), BUS_W'(cnt == TICK_DIV - 1));
      pend_rst = !rst_n;
      pend_evt = !rst_n || (bus_if.in_valid && bus_if.in_ready) || seq_restart || clr_updated;
    end
  end

  initial begin : driver
    int r;
    bit rp;
    rst_n           = 1'b0;
    seq_mode        = 1'b0;
    seq_restart     = 1'b0;
    clr_updated     = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_chan  = '0;
    model_reset();

    do_reset();
    idle(8);

    // Addressed write.
    send(1'b0, 3, 'h5A5, 1'b0, 1'b0);

    // Full sequential frame, then the wrap back to channel 0.
    pulse(1'b1, 1'b1);
    for (int k = 0; k < NUM_CH; k++) send(1'b1, k ^ 1, k, 1'b0, 1'b0);
    send(1'b1, 5, 'h7FF, 1'b0, 1'b0);

    // Out-of-range addressed writes.
    send(1'b0, 45, 'h123, 1'b0, 1'b0);
    send(1'b0, 63, 'h321, 1'b0, 1'b0);

    // Clear coincident with a write to channel 7 while flags are 0xFF.
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) send(1'b0, k, 'h40 + k, 1'b0, 1'b0);
    send(1'b0, 7, 'h0AA, 1'b0, 1'b1);

    // Restart coincident with the accept at the last pointer.
    pulse(1'b1, 1'b0);
    for (int k = 0; k < NUM_CH - 1; k++) send(1'b1, 0, k + 100, 1'b0, 1'b0);
    send(1'b1, 0, 'h3C3, 1'b1, 1'b0);
    send(1'b1, 0, 'h1E1, 1'b0, 1'b0);

    // Pointer holds across addressed-mode writes.
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send(1'b1, 0, 'h200 + k, 1'b0, 1'b0);
    send(1'b0, 20, 'h555, 1'b0, 1'b0);
    send(1'b1, 0, 'h666, 1'b0, 1'b0);

    // Randomised mix.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idle($urandom_range(1, 4));
      end else if (r == 1) begin
        rp = 1'($urandom_range(0, 1));
        pulse(rp, rp ? 1'($urandom_range(0, 1)) : 1'b1);
      end else begin
        send(1'($urandom_range(0, 1)), $urandom_range(0, 63), int'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end

    // Reset in the middle of a sequential frame.
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) send(1'b1, 0, 'h300 + k, 1'b0, 1'b0);
    do_reset();
    send(1'b1, 9, 'h2AB, 1'b0, 1'b0);
    idle(4);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
